// File: rtl/mips_pkg.sv
// Shared MIPS31 definitions: instruction field positions, default widths and the NOP encoding.
package mips_pkg;

   localparam int DEF_INST_W = 32;
   localparam int DEF_PC_W   = 32;

   // Top bit of each field; the low bit follows from the field width.
   localparam int OP_HI = 31;
   localparam int RS_HI = 25;
   localparam int RT_HI = 20;
   localparam int RD_HI = 15;
   localparam int SH_HI = 10;
   localparam int FN_HI = 5;

   localparam logic [DEF_INST_W-1:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b11
   } skid_state_t;

endpackage

// File: rtl/inst_fields.sv
// Combinational slicer splitting a 32-bit MIPS instruction word into its fields.
module inst_fields
   import mips_pkg::*;
(
   input  logic [31:0] inst,
   output logic [5:0]  op,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm16,
   output logic [25:0] index26
);

   assign op      = inst[OP_HI -: 6];
   assign rs      = inst[RS_HI -: 5];
   assign rt      = inst[RT_HI -: 5];
   assign rd      = inst[RD_HI -: 5];
   assign shamt   = inst[SH_HI -: 5];
   assign funct   = inst[FN_HI -: 6];
   // Raw immediate; sign/zero extension is left to the ext16 stage.
   assign imm16   = inst[15:0];
   assign index26 = inst[25:0];

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a two-entry skid buffer, valid/ready on both sides and flush.
module if_id_skid
   import mips_pkg::*;
#(
   parameter int INST_W = DEF_INST_W,
   parameter int PC_W   = DEF_PC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] in_inst,
   input  logic [PC_W-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              flush,
   output logic [INST_W-1:0] out_inst,
   output logic [PC_W-1:0]   out_pc,
   output logic [5:0]        out_op,
   output logic [4:0]        out_rs,
   output logic [4:0]        out_rt,
   output logic [4:0]        out_rd,
   output logic [4:0]        out_shamt,
   output logic [5:0]        out_funct,
   output logic [15:0]       out_imm16,
   output logic [25:0]       out_index26,
   output logic              out_nop
);

   skid_state_t       state_q, state_d;
   logic [INST_W-1:0] main_inst, skid_inst;
   logic [PC_W-1:0]   main_pc, skid_pc;
   logic              main_valid, skid_valid;
   logic              accept, consume;
   logic              load_main_in, load_main_skid, load_skid;

   // The state encoding is {skid_valid, main_valid}, so the valid bits are just state bits.
   assign main_valid = state_q[0];
   assign skid_valid = state_q[1];

   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign accept    = in_valid & in_ready;
   assign consume   = main_valid & out_ready;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d      = ONE;
               load_main_in = 1'b1;
            end
         end
         ONE: begin
            if (consume && accept) begin
               load_main_in = 1'b1;
            end else if (consume) begin
               state_d = EMPTY;
            end else if (accept) begin
               state_d   = TWO;
               load_skid = 1'b1;
            end
         end
         TWO: begin
            if (consume) begin
               state_d        = ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      // A flushed word must not even reach the stale data registers seen on the outputs.
      if (flush) begin
         state_d        = EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: data registers are reset too so the field outputs read zero straight out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_inst <= '0;
         main_pc   <= '0;
         skid_inst <= '0;
         skid_pc   <= '0;
      end else begin
         if (load_main_in) begin
            main_inst <= in_inst;
            main_pc   <= in_pc;
         end else if (load_main_skid) begin
            main_inst <= skid_inst;
            main_pc   <= skid_pc;
         end
         if (load_skid) begin
            skid_inst <= in_inst;
            skid_pc   <= in_pc;
         end
      end
   end

   assign out_inst = main_inst;
   assign out_pc   = main_pc;
   assign out_nop  = main_valid & (main_inst == NOP_WORD);

   inst_fields u_fields (
      .inst    (main_inst),
      .op      (out_op),
      .rs      (out_rs),
      .rt      (out_rt),
      .rd      (out_rd),
      .shamt   (out_shamt),
      .funct   (out_funct),
      .imm16   (out_imm16),
      .index26 (out_index26)
   );

endmodule

// File: tb/tb_if_id_skid.sv
// Self-checking bench for if_id_skid: queue scoreboard of accepted words plus directed field checks.
module tb_if_id_skid;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, flush, out_nop;
   logic [31:0] in_inst, in_pc, out_inst, out_pc;
   logic [5:0]  out_op, out_funct;
   logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
   logic [15:0] out_imm16;
   logic [25:0] out_index26;

   entry_t q[$];
   int     errors = 0;
   int     checks = 0;
   int     n_consume = 0;

   always #5 clk = ~clk;

   if_id_skid dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_inst     (in_inst),
      .in_pc       (in_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .flush       (flush),
      .out_inst    (out_inst),
      .out_pc      (out_pc),
      .out_op      (out_op),
      .out_rs      (out_rs),
      .out_rt      (out_rt),
      .out_rd      (out_rd),
      .out_shamt   (out_shamt),
      .out_funct   (out_funct),
      .out_imm16   (out_imm16),
      .out_index26 (out_index26),
      .out_nop     (out_nop)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check against the scoreboard, update it, then advance.
   task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl);
      logic   cons, acc;
      entry_t e;
      in_valid  = v;
      in_inst   = v ? inst : 'x;
      in_pc     = v ? pc : 'x;
      out_ready = ordy;
      flush     = fl;
      check("in_ready", 64'(in_ready), 64'(q.size() < 2));
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      cons = (q.size() > 0) && ordy;
      acc  = v && (q.size() < 2);
      if (cons) begin
         e = q.pop_front();
         check("head_inst", 64'(out_inst), 64'(e.inst));
         check("head_pc", 64'(out_pc), 64'(e.pc));
         check("head_nop", 64'(out_nop), 64'(e.inst == 32'h0));
         n_consume++;
      end
      if (fl) q.delete();
      else if (acc) q.push_back('{inst: inst, pc: pc});
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_inst", 64'(out_inst), 64'd0);
      check("rst_out_pc", 64'(out_pc), 64'd0);
      check("rst_out_nop", 64'(out_nop), 64'd0);
      check("rst_index26", 64'(out_index26), 64'd0);

      // Stream one lui word.
      cycle(1'b1, 32'h3C01_1234, 32'h0040_0000, 1'b1, 1'b0);
      check("lui_valid", 64'(out_valid), 64'd1);
      check("lui_op", 64'(out_op), 64'h0F);
      check("lui_rs", 64'(out_rs), 64'd0);
      check("lui_rt", 64'(out_rt), 64'd1);
      check("lui_imm16", 64'(out_imm16), 64'h1234);
      check("lui_rd", 64'(out_rd), 64'd2);
      check("lui_funct", 64'(out_funct), 64'h34);
      check("lui_shamt", 64'(out_shamt), 64'h08);
      check("lui_pc", 64'(out_pc), 64'h0040_0000);
      check("lui_in_ready", 64'(in_ready), 64'd1);

      // Stall absorb: B lands in the skid while A stays on the outputs.
      cycle(1'b1, 32'h2002_FFFF, 32'h0040_0004, 1'b0, 1'b0);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_hold_inst", 64'(out_inst), 64'h3C01_1234);
      cycle(1'b1, 32'hDEAD_BEEF, 32'h0040_0008, 1'b0, 1'b0);
      check("stall_hold2_inst", 64'(out_inst), 64'h3C01_1234);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("skid_out_imm16", 64'(out_imm16), 64'hFFFF);
      check("skid_out_rt", 64'(out_rt), 64'd2);
      check("skid_in_ready", 64'(in_ready), 64'd1);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("drained", 64'(q.size()), 64'd0);

      // Back-to-back: 8 words, one consume per cycle.
      n_consume = 0;
      for (int i = 0; i < 9; i++)
         cycle(i < 8, 32'h2400_0000 | 32'(i), 32'h0000_1000 + 32'(4 * i), 1'b1, 1'b0);
      check("b2b_consumes", 64'(n_consume), 64'd8);

      // Flush in TWO drops held words and the concurrent word C.
      cycle(1'b1, 32'h1111_0001, 32'h0000_2000, 1'b0, 1'b0);
      cycle(1'b1, 32'h1111_0002, 32'h0000_2004, 1'b0, 1'b0);
      check("two_in_ready", 64'(in_ready), 64'd0);
      cycle(1'b1, 32'h0800_0010, 32'h0000_2008, 1'b0, 1'b1);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      check("flush_no_c", 64'(out_inst === 32'h0800_0010), 64'd0);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("flush_no_c_later", 64'(out_inst === 32'h0800_0010), 64'd0);

      // Flush with a concurrent consume still delivers that word.
      cycle(1'b1, 32'h1234_5678, 32'h0000_3000, 1'b0, 1'b0);
      cycle(1'b1, 32'h8765_4321, 32'h0000_3004, 1'b1, 1'b1);
      check("flush_cons_valid", 64'(out_valid), 64'd0);

      // NOP flag and its gating.
      cycle(1'b1, 32'h0000_0000, 32'h0000_4000, 1'b0, 1'b0);
      check("nop_flag", 64'(out_nop), 64'd1);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("nop_gone_valid", 64'(out_valid), 64'd0);
      check("nop_gone_flag", 64'(out_nop), 64'd0);

      // Reset overrides flush and both handshakes while in TWO.
      cycle(1'b1, 32'hAAAA_0001, 32'h0000_5000, 1'b0, 1'b0);
      cycle(1'b1, 32'hAAAA_0002, 32'h0000_5004, 1'b0, 1'b0);
      check("pre_rst_two", 64'(in_ready), 64'd0);
      rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_inst = 32'hBBBB_0003; out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      q.delete();
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      check("mid_rst_out_inst", 64'(out_inst), 64'd0);
      cycle(1'b1, 32'h0C00_0040, 32'h0000_6000, 1'b1, 1'b0);
      check("post_rst_op", 64'(out_op), 64'h03);
      check("post_rst_index26", 64'(out_index26), 64'h40);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
- Fetch-to-decode pipeline register for the MIPS31 core, with a two-entry skid buffer and valid/ready handshakes on both sides.
- Latches each fetched instruction word and its PC.
- Presents the split instruction fields to decode: imm16 feeds ext16, rs/rt feed the register file, op/funct feed the controller.
- Absorbs one extra word when decode stalls, and drops all held words on a flush.

Parameters:
- INST_W, 32, instruction word width. The field slicing below is fixed for 32.
- PC_W, 32, program counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch presents a word
- in_ready  out  1  buffer can accept; equals NOT skid_valid (registered, no combinational path from out_ready)
- in_inst  in  INST_W  fetched instruction
- in_pc  in  PC_W  PC of fetched instruction
- out_valid  out  1  main entry holds a word
- out_ready  in  1  decode consumes this cycle
- flush  in  1  branch/jump/exception redirect; discard held words
- out_inst  out  INST_W  main-entry instruction
- out_pc  out  PC_W  main-entry PC
- out_op  out  6  out_inst[31:26]
- out_rs  out  5  out_inst[25:21]
- out_rt  out  5  out_inst[20:16]
- out_rd  out  5  out_inst[15:11]
- out_shamt  out  5  out_inst[10:6]
- out_funct  out  6  out_inst[5:0]
- out_imm16  out  16  out_inst[15:0], raw, unextended
- out_index26  out  26  out_inst[25:0]
- out_nop  out  1  out_valid AND out_inst==32'h0

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset state: main_valid=0, skid_valid=0, inst/pc registers=0. Therefore out_valid=0, in_ready=1, all field outputs 0, out_nop=0. Reset overrides flush and every handshake in the same cycle.
- Transfer definitions: accept = in_valid & in_ready; consume = out_valid & out_ready.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY(00): accept -> ONE, word goes to main.
  - ONE(01), consume & accept -> ONE, main loads the new word.
  - ONE(01), consume only -> EMPTY.
  - ONE(01), accept only -> TWO, word goes to skid.
  - ONE(01), neither -> hold.
  - TWO(11): in_ready=0, so no accept. Consume -> ONE, main loads the skid contents and skid_valid clears. Otherwise hold.
- Ordering: strict FIFO. The skid entry never bypasses the main entry.
- Latency: an accepted word appears on the out_* ports the next cycle (1-cycle latency).
- Stability: while out_valid & !out_ready, every out_* output is held stable.
- Flush:
  - Next state is EMPTY regardless of current state.
  - An accept in the same cycle is dropped, so fetch must re-issue from the redirected PC.
  - A consume in the same cycle still counts; decode sees that word this cycle.
  - Data registers need not clear; only the valid bits clear.
- Invalid-data outputs: when out_valid=0, the field outputs show the stale main register. out_nop is gated to 0.
- Field outputs are purely combinational slices of main_inst. No sign or zero extension is done here; that belongs to ext16/ext16s downstream.
- in_inst/in_pc are sampled only on accept. X on these inputs is harmless when in_valid=0.
- Throughput: 1 word/cycle while out_ready stays high. The maximum stall depth absorbed is 1 extra word.

Decomposition:
- Shared package (mips_pkg), holding:
  - field bit-position constants: OP_HI=31, RS_HI=25, RT_HI=20, RD_HI=15, SH_HI=10, FN_HI=5.
  - INST_W and PC_W defaults.
  - NOP_WORD=32'h0.
- Sub-module: one, inst_fields, a combinational slicer from inst to op/rs/rt/rd/shamt/funct/imm16/index26. It is reused later by the ID/EX stage.
- The skid control stays in the top module.

Test Plan:
- Reset then stream: rst for 2 cycles, then in_inst=32'h3C01_1234 (lui) at pc=32'h0040_0000 with out_ready=1. Next cycle: out_valid=1, out_op=6'h0F, out_rt=5'd1, out_imm16=16'h1234, out_pc=32'h0040_0000, in_ready=1.
- Stall absorb: with main holding A, drop out_ready and present B=32'h2002_FFFF. Required: skid captures B and in_ready=0 next cycle, while A stays on the outputs. Raise out_ready: A consumed, then B on the outputs (out_imm16=16'hFFFF) with in_ready=1. No word lost or duplicated.
- Back-to-back: 8 sequential words with out_ready=1 every cycle. Required: 8 consumes in 8 consecutive cycles, with PCs in increasing order by 4.
- Flush in TWO: state TWO, then pulse flush with in_valid=1 and C=32'h0800_0010. Next cycle: out_valid=0, in_ready=1, and C never appears on the outputs.
- NOP flag: accept 32'h0000_0000, then out_nop=1. After consume with in_valid=0: out_valid=0, out_nop=0.
- Reset mid-operation: in TWO, assert rst together with flush, in_valid and out_ready. Next cycle: out_valid=0, in_ready=1, out_inst=0.
